// File: rtl/pc_seq_pkg.sv
// Shared next-PC mode encoding and branch-condition helper for the PC sequencer and its decoders.
package pc_seq_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SEQ   = 3'b000;
    localparam logic [MODE_W-1:0] MODE_BCOND = 3'b001;
    localparam logic [MODE_W-1:0] MODE_JR    = 3'b010;
    localparam logic [MODE_W-1:0] MODE_JMP   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_CALL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_RET   = 3'b101;

    // Conditional branch is taken when the polarity bit disagrees with the zero flag.
    function automatic logic branch_taken(input logic ps, input logic zero);
        return ps ^ zero;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is ignored.
module return_stack #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, full_q;

    // Write pointer wraps modulo RAS_DEPTH in both directions.
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
    end

    // Pointer and saturating occupancy update.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_inc;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control state, with status flags registered from the post-edge occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout  = mem_q[ptr_dec];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: combinational next-PC select feeding a registered PC plus return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        mode,
    input  logic              PS,
    input  logic              zero,
    input  logic [ADDR_W-1:0] BrA,
    input  logic [ADDR_W-1:0] RAA,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_dout;
    logic              err_q, err_d;
    logic              is_call, is_ret, push, pop;
    logic              stk_empty, stk_full;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Stack side effects only happen on an unstalled cycle; pop on empty is routed to RAA instead.
    always_comb begin
        is_call = (mode == MODE_CALL);
        is_ret  = (mode == MODE_RET);
        push    = !stall && is_call;
        pop     = !stall && is_ret && !stk_empty;
        err_d   = !stall && is_ret && stk_empty;
    end

    // Next-PC select; reserved encodings fall through to sequential.
    always_comb begin
        pc_d = pc_inc;
        case (mode)
            MODE_SEQ:   pc_d = pc_inc;
            MODE_BCOND: pc_d = branch_taken(PS, zero) ? BrA : pc_inc;
            MODE_JR:    pc_d = RAA;
            MODE_JMP:   pc_d = BrA;
            MODE_CALL:  pc_d = BrA;
            MODE_RET:   pc_d = stk_empty ? RAA : ras_dout;
            default:    pc_d = pc_inc;
        endcase
    end

    // PC and error-pulse registers; reset wins over stall and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!stall) begin
                pc_q <= pc_d;
            end
            err_q <= err_d;
        end
    end

    return_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (pc_inc),
        .dout (ras_dout),
        .empty(stk_empty),
        .full (stk_full)
    );

    assign pc        = pc_q;
    assign ras_empty = stk_empty;
    assign ras_full  = stk_full;
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each edge's outputs.
module tb_pc_sequencer;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, stall, PS, zero;
    logic [2:0]    mode;
    logic [AW-1:0] BrA, RAA, pc;
    logic          ras_empty, ras_full, ras_err;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .mode(mode), .PS(PS), .zero(zero),
        .BrA(BrA), .RAA(RAA), .pc(pc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          empty;
        logic          full;
        logic          err;
    } obs_t;

    typedef struct packed {
        logic          rst;
        logic          stall;
        logic [2:0]    mode;
        logic          ps;
        logic          z;
        logic [AW-1:0] bra;
        logic [AW-1:0] raa;
    } stim_t;

    obs_t          sb[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_err;

    function automatic stim_t mk(input logic r, input logic s, input logic [2:0] m,
                                 input logic ps, input logic z,
                                 input logic [AW-1:0] bra, input logic [AW-1:0] raa);
        stim_t t;
        t.rst = r; t.stall = s; t.mode = m; t.ps = ps; t.z = z; t.bra = bra; t.raa = raa;
        return t;
    endfunction

    // Drive one cycle, advance the reference model, queue the expected post-edge outputs.
    task automatic apply(input stim_t s);
        obs_t e;
        @(negedge clk);
        rst = s.rst; stall = s.stall; mode = s.mode; PS = s.ps; zero = s.z;
        BrA = s.bra; RAA = s.raa;
        m_err = 1'b0;
        if (s.rst) begin
            m_pc = '0;
            m_stk.delete();
        end else if (!s.stall) begin
            case (s.mode)
                3'b001: m_pc = (s.ps != s.z) ? s.bra : m_pc + 32'd1;
                3'b010: m_pc = s.raa;
                3'b011: m_pc = s.bra;
                3'b100: begin
                    if (m_stk.size() == int'(DEPTH)) void'(m_stk.pop_front());
                    m_stk.push_back(m_pc + 32'd1);
                    m_pc = s.bra;
                end
                3'b101: begin
                    if (m_stk.size() == 0) begin
                        m_pc  = s.raa;
                        m_err = 1'b1;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: m_pc = m_pc + 32'd1;
            endcase
        end
        e.pc    = m_pc;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == int'(DEPTH));
        e.err   = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        apply(mk(1, 1, 3'b100, 0, 0, 32'h55, 32'h66));
        e = sb.pop_front();
        g = {pc, ras_empty, ras_full, ras_err};
        vectors++;
        if (g !== e || g !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: {pc,empty,full,err} got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_seq();
        stim_t q[$];
        obs_t  e, g;
        q.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 3'b110, 0, 0, 32'h99, 32'h99));
        q.push_back(mk(0, 0, 3'b111, 0, 0, 32'h99, 32'h99));
        q.push_back(mk(0, 0, 3'b010, 0, 0, 32'h99, 32'h1234));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL seq[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
            if (i == 3) begin
                vectors++;
                if (pc !== 32'd3) begin
                    miscompares++;
                    $display("FAIL seq_pc3: pc got=%h exp=00000003", pc);
                end
            end
        end
    endtask

    task automatic test_bcond();
        stim_t q[$];
        obs_t  e, g;
        q.push_back(mk(0, 0, 3'b011, 0, 0, 32'h5, 0));
        q.push_back(mk(0, 0, 3'b001, 0, 1, 32'h40, 0));
        q.push_back(mk(0, 0, 3'b011, 0, 0, 32'h5, 0));
        q.push_back(mk(0, 0, 3'b001, 0, 0, 32'h40, 0));
        q.push_back(mk(0, 0, 3'b001, 1, 1, 32'h80, 0));
        q.push_back(mk(0, 0, 3'b001, 1, 0, 32'h90, 0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL bcond[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
            if (i == 1 || i == 3) begin
                vectors++;
                if (pc !== ((i == 1) ? 32'h40 : 32'h6)) begin
                    miscompares++;
                    $display("FAIL bcond_pc[%0d]: pc got=%h", i, pc);
                end
            end
        end
    endtask

    task automatic test_call_ret();
        stim_t q[$];
        obs_t  e, g;
        q.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 3'b011, 0, 0, 32'h10, 0));
        q.push_back(mk(0, 0, 3'b100, 0, 0, 32'h80, 0));
        q.push_back(mk(0, 0, 3'b101, 0, 0, 0, 32'hDEAD));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL call_ret[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
        end
        vectors++;
        if (pc !== 32'h11 || ras_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL call_ret_final: pc=%h empty=%b exp pc=00000011 empty=1", pc, ras_empty);
        end
    endtask

    task automatic test_overflow();
        stim_t         q[$];
        obs_t          e, g;
        logic [AW-1:0] pops[4];
        pops[0] = 32'h401; pops[1] = 32'h301; pops[2] = 32'h201; pops[3] = 32'h101;
        q.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) q.push_back(mk(0, 0, 3'b100, 0, 0, AW'(k * 32'h100), 0));
        for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 3'b101, 0, 0, 0, 32'hBAD));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL overflow[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
            if (i == 4) begin
                vectors++;
                if (ras_full !== 1'b1) begin
                    miscompares++;
                    $display("FAIL overflow_full: ras_full got=%b exp=1", ras_full);
                end
            end
            if (i >= 6) begin
                vectors++;
                if (pc !== pops[i-6] || ras_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL overflow_pop[%0d]: pc=%h err=%b exp pc=%h err=0", i - 6, pc, ras_err, pops[i-6]);
                end
            end
        end
    endtask

    task automatic test_empty_ret_stall();
        stim_t q[$];
        obs_t  e, g;
        q.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 3'b101, 0, 0, 0, 32'h77));
        q.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 3'b100, 0, 0, 32'h300, 0));
        q.push_back(mk(0, 1, 3'b101, 0, 0, 0, 32'h44));
        q.push_back(mk(0, 0, 3'b100, 0, 0, 32'h500, 0));
        q.push_back(mk(0, 1, 3'b101, 0, 0, 0, 32'h44));
        q.push_back(mk(0, 0, 3'b101, 0, 0, 0, 32'h44));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL empty_stall[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
            if (i == 1) begin
                vectors++;
                if (pc !== 32'h77 || ras_err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL empty_ret: pc=%h err=%b exp pc=00000077 err=1", pc, ras_err);
                end
            end
        end
    endtask

    task automatic test_wrap_reset();
        stim_t q[$];
        obs_t  e, g;
        q.push_back(mk(0, 0, 3'b011, 0, 0, 32'hFFFF_FFFF, 0));
        q.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 3'b100, 0, 0, 32'h20, 0));
        q.push_back(mk(1, 0, 3'b100, 0, 0, 32'h30, 0));
        q.push_back(mk(0, 0, 3'b101, 0, 0, 0, 32'h88));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL wrap_reset[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
            if (i == 1 || i == 3) begin
                vectors++;
                if (pc !== 32'h0 || (i == 3 && ras_empty !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL wrap_reset_pc[%0d]: pc=%h empty=%b exp pc=00000000", i, pc, ras_empty);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t  e, g;
        stim_t s;
        for (int i = 0; i < 400; i++) begin
            s = mk(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom(), $urandom());
            if ($urandom_range(0, 2) == 0) s.mode = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101;
            apply(s);
            e = sb.pop_front();
            g = {pc, ras_empty, ras_full, ras_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL random[%0d]: {pc,empty,full,err} got=%h exp=%h", i, g, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; mode = 3'b000; PS = 1'b0; zero = 1'b0; BrA = '0; RAA = '0;
        test_reset();
        test_seq();
        test_bcond();
        test_call_ret();
        test_overflow();
        test_empty_ret_stall();
        test_wrap_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC and target width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries; legal range 2..16.
REQ-003 SHALL have port clk, input, 1, the only clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, hold PC and stack when high.
REQ-006 SHALL have port mode, input, 3, next-PC select (encoding per REQ-012).
REQ-007 SHALL have port PS, input, 1, branch polarity; the condition is taken when (PS ^ zero) = 1.
REQ-008 SHALL have port zero, input, 1, ALU zero flag.
REQ-009 SHALL have ports BrA and RAA, inputs, ADDR_W each, branch/jump-immediate target and register target.
REQ-010 SHALL have port pc, output, ADDR_W, the registered program counter.
REQ-011 SHALL have outputs ras_empty (1), ras_full (1), ras_err (1) for stack status and a one-cycle error pulse.

Function
REQ-012 SHALL decode mode: 000 SEQ, 001 BCOND, 010 JR, 011 JMP, 100 CALL, 101 RET; 110/111 SHALL behave as SEQ.
REQ-013 SHALL compute pc_inc = pc + 1 internally, modulo 2^ADDR_W; 0xFFFFFFFF SHALL wrap to 0.
REQ-014 SHALL compute next PC as follows: SEQ -> pc_inc; BCOND -> BrA if (PS ^ zero) else pc_inc; JR -> RAA; JMP -> BrA; CALL -> BrA; RET -> top of stack.
REQ-015 SHALL load pc with the next PC at every clock edge where stall = 0, with one-cycle latency from mode to pc.
REQ-016 SHALL hold pc, the stack contents, and the pointer when stall = 1; CALL/RET under stall SHALL have no side effect.
REQ-017 On CALL, SHALL push pc_inc and increment the pointer.
REQ-018 On CALL when full, SHALL overwrite the oldest entry as a circular buffer, keep ras_full = 1, and not pulse ras_err.
REQ-019 On RET, SHALL pop the top entry and decrement the pointer.
REQ-020 On RET when empty, SHALL load pc with RAA, leave the pointer unchanged, and pulse ras_err high for exactly one cycle.
REQ-021 ras_empty and ras_full SHALL be registered and SHALL reflect occupancy after the current edge (0 and RAS_DEPTH respectively).
REQ-022 Occupancy SHALL saturate at RAS_DEPTH and SHALL never underflow below 0.
REQ-023 ras_err SHALL be 0 on every cycle that is not an empty-stack RET without stall.

Reset
REQ-024 With rst = 1 at a clock edge, SHALL set pc = 0, occupancy = 0, ras_empty = 1, ras_full = 0, ras_err = 0; stack entry contents are don't-care.
REQ-025 Reset SHALL override stall and mode, including reset asserted mid-CALL or mid-RET.
REQ-026 At the first edge with rst = 0, SHALL act on the current mode and inputs.

Structure
REQ-027 SHALL place the mode encoding localparams/enum (SEQ..RET) in shared package pc_seq_pkg for decoder reuse.
REQ-028 SHALL implement the stack as sub-module return_stack (params ADDR_W, RAS_DEPTH; ports push, pop, din, dout, empty, full).
REQ-029 SHALL keep the next-PC select combinational and only pc registered in pc_sequencer.

Verification
REQ-030 Reset, then 3 cycles of SEQ -> pc = 0, 1, 2, 3.
REQ-031 pc = 5, BCOND, PS = 0, zero = 1, BrA = 0x40 -> pc = 0x40; repeat with zero = 0 -> pc = 6.
REQ-032 pc = 0x10, CALL, BrA = 0x80 -> pc = 0x80, ras_empty = 0; then RET -> pc = 0x11, ras_empty = 1.
REQ-033 RAS_DEPTH = 4, 5 CALLs from pc = 0, 0x100, 0x200, 0x300, 0x400 (BrA set accordingly), then 4 RETs -> pops return 0x401, 0x301, 0x201, 0x101; ras_full = 1 after the 4th call; no ras_err.
REQ-034 Empty stack, RET with RAA = 0x77 -> pc = 0x77, ras_err high one cycle; stall = 1 with CALL -> pc and occupancy unchanged.
REQ-035 pc = 0xFFFFFFFF, SEQ -> pc = 0; rst = 1 during a CALL cycle -> pc = 0, ras_empty = 1.
